// File: rtl/vj_pkg.sv
// Shared types and constants for the Viola-Jones window scheduler.
package vj_pkg;

  localparam int WIN_SIZE = 24;
  localparam int COORD_W  = 32;
  localparam int LEVEL_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_LVL,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } vj_scan_state_t;

  // Coordinates are carried at full report width so the tag can feed face_coords directly.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [LEVEL_W-1:0] level;
  } vj_tag_t;

endpackage

// File: rtl/vj_tag_pipe.sv
// Resettable delay line that carries each window tag alongside its cascade evaluation.
module vj_tag_pipe
  import vj_pkg::*;
#(
  parameter int DEPTH = 26
) (
  input  logic    clock,
  input  logic    reset,
  input  vj_tag_t tag_in,
  output vj_tag_t tag_out
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
      vj_tag_t stage_reg;
      if (gi == 0) begin : gen_head
        always_ff @(posedge clock) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= tag_in;
        end
      end else begin : gen_body
        always_ff @(posedge clock) begin
          if (reset) stage_reg <= '0;
          else       stage_reg <= gen_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign tag_out = gen_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/vj_scan_ctrl.sv
// Walks the image pyramid level by level, issues every 24x24 window position to the cascade
// and reports the coordinates of windows the cascade accepts.
module vj_scan_ctrl
  import vj_pkg::*;
#(
  parameter int LEVELS   = 10,
  parameter int PIPE_LAT = 26,
  parameter int DIM_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        level_req,
  input  logic                        level_ready,
  input  logic [DIM_W-1:0]            level_w,
  input  logic [DIM_W-1:0]            level_h,
  output logic                        win_valid,
  output logic [DIM_W-1:0]            row_index,
  output logic [DIM_W-1:0]            col_index,
  input  logic                        face_detected,
  output logic                        face_coords_ready,
  output logic [1:0][COORD_W-1:0]     face_coords,
  output logic [LEVEL_W-1:0]          pyramid_number,
  output logic                        vj_pipeline_done
);

  localparam int CNT_W = $clog2(PIPE_LAT + 1);
  localparam logic [DIM_W-1:0] WIN_D = DIM_W'(WIN_SIZE);

  vj_scan_state_t     state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [DIM_W-1:0]   w_reg, w_next;
  logic [DIM_W-1:0]   h_reg, h_next;
  logic [DIM_W-1:0]   row_reg, row_next;
  logic [DIM_W-1:0]   col_reg, col_next;
  logic [CNT_W-1:0]   drain_cnt_reg, drain_cnt_next;

  logic               det_valid_reg;
  logic [COORD_W-1:0] det_row_reg;
  logic [COORD_W-1:0] det_col_reg;
  logic [LEVEL_W-1:0] det_level_reg;

  vj_tag_t tag_in;
  vj_tag_t tag_out;

  // Only evaluated in SCAN, where the latched dimensions are known to be >= WIN_SIZE.
  logic [DIM_W-1:0] last_col;
  logic [DIM_W-1:0] last_row;
  assign last_col = w_reg - WIN_D;
  assign last_row = h_reg - WIN_D;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      level_reg     <= '0;
      w_reg         <= '0;
      h_reg         <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      w_reg         <= w_next;
      h_reg         <= h_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    level_next     = level_reg;
    w_next         = w_reg;
    h_next         = h_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_REQ;
          level_next = '0;
        end
      end
      S_REQ: state_next = S_WAIT_LVL;
      S_WAIT_LVL: begin
        if (level_ready) begin
          w_next         = level_w;
          h_next         = level_h;
          row_next       = '0;
          col_next       = '0;
          drain_cnt_next = '0;
          // A level smaller than one window contributes nothing but still drains.
          if (level_w < WIN_D || level_h < WIN_D) state_next = S_DRAIN;
          else                                    state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (col_reg == last_col) begin
          col_next = '0;
          if (row_reg == last_row) begin
            state_next     = S_DRAIN;
            drain_cnt_next = '0;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == CNT_W'(PIPE_LAT)) begin
          if (level_reg == LEVEL_W'(LEVELS - 1)) begin
            state_next = S_DONE;
          end else begin
            level_next = level_reg + 1'b1;
            state_next = S_REQ;
          end
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy             = (state_reg != S_IDLE);
  assign level_req        = (state_reg == S_REQ);
  assign win_valid        = (state_reg == S_SCAN);
  assign vj_pipeline_done = (state_reg == S_DONE);
  assign row_index        = row_reg;
  assign col_index        = col_reg;

  always_comb begin
    tag_in = '0;
    if (win_valid) begin
      tag_in.valid = 1'b1;
      tag_in.row   = COORD_W'(row_reg);
      tag_in.col   = COORD_W'(col_reg);
      tag_in.level = level_reg;
    end
  end

  vj_tag_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Results arriving with an empty tag slot belong to no window and are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      det_valid_reg <= 1'b0;
      det_row_reg   <= '0;
      det_col_reg   <= '0;
      det_level_reg <= '0;
    end else begin
      det_valid_reg <= tag_out.valid & face_detected;
      if (tag_out.valid && face_detected) begin
        det_row_reg   <= tag_out.row;
        det_col_reg   <= tag_out.col;
        det_level_reg <= tag_out.level;
      end
    end
  end

  assign face_coords_ready = det_valid_reg;
  assign face_coords[0]    = det_row_reg;
  assign face_coords[1]    = det_col_reg;
  assign pyramid_number    = det_valid_reg ? det_level_reg : level_reg;

endmodule

// File: tb/tb_vj_scan_ctrl.sv
// Directed bench for vj_scan_ctrl with a 3-cycle pyramid builder model and event queues.
module tb_vj_scan_ctrl;
  import vj_pkg::*;

  localparam int LEVELS   = 2;
  localparam int PIPE_LAT = 4;
  localparam int DIM_W    = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    busy;
  logic                    level_req;
  logic                    level_ready = 1'b0;
  logic [DIM_W-1:0]        level_w = '0;
  logic [DIM_W-1:0]        level_h = '0;
  logic                    win_valid;
  logic [DIM_W-1:0]        row_index;
  logic [DIM_W-1:0]        col_index;
  logic                    face_detected = 1'b0;
  logic                    face_coords_ready;
  logic [1:0][COORD_W-1:0] face_coords;
  logic [LEVEL_W-1:0]      pyramid_number;
  logic                    vj_pipeline_done;

  vj_scan_ctrl #(
    .LEVELS   (LEVELS),
    .PIPE_LAT (PIPE_LAT),
    .DIM_W    (DIM_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .level_req         (level_req),
    .level_ready       (level_ready),
    .level_w           (level_w),
    .level_h           (level_h),
    .win_valid         (win_valid),
    .row_index         (row_index),
    .col_index         (col_index),
    .face_detected     (face_detected),
    .face_coords_ready (face_coords_ready),
    .face_coords       (face_coords),
    .pyramid_number    (pyramid_number),
    .vj_pipeline_done  (vj_pipeline_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int row;
    int col;
    int lvl;
  } ev_t;

  typedef struct {
    int row;
    int col;
    int off;
  } win_vec_t;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ev_t  win_q[$];
  ev_t  det_q[$];
  int   done_q[$];
  int   rdy_q[$];

  int   lw[2];
  int   lh[2];
  bit   fd_en = 1'b0;
  int   fd_row = 0;
  int   fd_col = 0;
  bit   spur_en = 1'b0;

  int         fd_cycle = -100;
  int         req_lvl = 0;
  logic [3:0] req_hist = '0;
  bit         spur_wait = 1'b0;

  // Monitor, builder model and cascade-result driver, all on the falling edge.
  always @(negedge clock) begin
    if (win_valid) begin
      win_q.push_back('{cyc, int'(row_index), int'(col_index), int'(pyramid_number)});
      $display("[%0d] window row=%0d col=%0d level=%0d", cyc, row_index, col_index, pyramid_number);
      if (fd_en && int'(row_index) == fd_row && int'(col_index) == fd_col)
        fd_cycle = cyc + PIPE_LAT;
    end
    if (face_coords_ready) begin
      det_q.push_back('{cyc, int'(face_coords[0]), int'(face_coords[1]), int'(pyramid_number)});
      $display("[%0d] detection row=%0d col=%0d level=%0d", cyc, face_coords[0], face_coords[1], pyramid_number);
    end
    if (vj_pipeline_done) begin
      done_q.push_back(cyc);
      $display("[%0d] pipeline done", cyc);
    end
    if (level_req) begin
      req_lvl   = int'(pyramid_number);
      spur_wait = 1'b1;
    end
    req_hist    = {req_hist[2:0], level_req};
    level_ready = req_hist[3];
    if (req_hist[3]) begin
      level_w = DIM_W'(lw[req_lvl]);
      level_h = DIM_W'(lh[req_lvl]);
      rdy_q.push_back(cyc);
      $display("[%0d] level %0d ready %0dx%0d", cyc, req_lvl, lw[req_lvl], lh[req_lvl]);
    end
    face_detected = (fd_cycle == cyc) || (spur_en && spur_wait);
    if (req_hist[3]) spur_wait = 1'b0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_done(input int base, input int limit);
    for (int i = 0; i < limit && done_q.size() <= base; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_level_req"}, level_req, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_row_index"}, row_index, 0);
    check({tag, "_col_index"}, col_index, 0);
    check({tag, "_ready"},     face_coords_ready, 0);
    check({tag, "_coords"},    longint'(face_coords[0] | face_coords[1]), 0);
    check({tag, "_pyramid"},   pyramid_number, 0);
    check({tag, "_done"},      vj_pipeline_done, 0);
  endtask

  win_vec_t vecs[4];
  int s, wb, db, dnb, rb, c;

  initial begin
    vecs[0] = '{0, 0, 5};
    vecs[1] = '{0, 1, 6};
    vecs[2] = '{1, 0, 7};
    vecs[3] = '{1, 1, 8};
    lw[0] = 25; lh[0] = 25; lw[1] = 20; lh[1] = 30;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick();

    // Two levels: 25x25 with one detection at (1,0), then a skipped 20x30; extra start mid-scan.
    fd_en = 1'b1; fd_row = 1; fd_col = 0;
    wb = win_q.size(); db = det_q.size(); dnb = done_q.size(); rb = rdy_q.size();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_level_req", level_req, 1);
    tick();
    check("level_req_pulse", level_req, 0);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dnb, 100);
    repeat (10) tick();
    fd_en = 1'b0;
    check("a_win_count", win_q.size() - wb, 4);
    for (int i = 0; i < 4; i++) begin
      if (win_q.size() > wb + i) begin
        check($sformatf("a_win%0d_row", i), win_q[wb+i].row, vecs[i].row);
        check($sformatf("a_win%0d_col", i), win_q[wb+i].col, vecs[i].col);
        check($sformatf("a_win%0d_cyc", i), win_q[wb+i].cyc - s, vecs[i].off);
        check($sformatf("a_win%0d_lvl", i), win_q[wb+i].lvl, 0);
      end
    end
    check("a_det_count", det_q.size() - db, 1);
    if (det_q.size() > db) begin
      check("a_det_cyc", det_q[db].cyc - s, 12);
      check("a_det_row", det_q[db].row, 1);
      check("a_det_col", det_q[db].col, 0);
      check("a_det_lvl", det_q[db].lvl, 0);
    end
    check("a_ready_count", rdy_q.size() - rb, 2);
    check("a_done_count", done_q.size() - dnb, 1);
    if (done_q.size() > dnb) begin
      check("a_done_cyc", done_q[dnb] - s, 23);
      if (rdy_q.size() > rb + 1)
        check("a_done_after_skip_ready", done_q[dnb] - rdy_q[rb+1], 6);
    end
    check("a_busy_after", busy, 0);

    // Exact 24x24 level; result bus held high during REQ and WAIT_LVL only.
    lw[0] = 24; lh[0] = 24; lw[1] = 20; lh[1] = 30;
    spur_en = 1'b1;
    wb = win_q.size(); db = det_q.size(); dnb = done_q.size();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    wait_done(dnb, 100);
    repeat (10) tick();
    spur_en = 1'b0;
    check("b_win_count", win_q.size() - wb, 1);
    if (win_q.size() > wb) begin
      check("b_win_cyc", win_q[wb].cyc - s, 5);
      check("b_win_row", win_q[wb].row, 0);
      check("b_win_col", win_q[wb].col, 0);
    end
    check("b_det_count", det_q.size() - db, 0);
    check("b_done_count", done_q.size() - dnb, 1);
    if (done_q.size() > dnb) check("b_done_cyc", done_q[dnb] - s, 20);

    // Reset while scanning a 30x30 level, with a result due after the reset.
    lw[0] = 30; lh[0] = 30;
    fd_en = 1'b1; fd_row = 0; fd_col = 2;
    wb = win_q.size(); db = det_q.size(); dnb = done_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && (win_q.size() - wb) < 3; i++) tick();
    check("c_reached_scan", win_q.size() - wb, 3);
    reset = 1'b1;
    c = cyc;
    tick();
    reset = 1'b0;
    check("c_reset_cycle", cyc - c, 1);
    check_all_zero("c_after_reset");
    repeat (40) tick();
    fd_en = 1'b0;
    check("c_win_count", win_q.size() - wb, 3);
    check("c_det_count", det_q.size() - db, 0);
    check("c_done_count", done_q.size() - dnb, 0);
    check("c_busy_idle", busy, 0);

    // Fresh start after the abort restarts from level 0.
    lw[0] = 25; lh[0] = 25; lw[1] = 20; lh[1] = 30;
    wb = win_q.size(); db = det_q.size(); dnb = done_q.size();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check("d_pyramid_start", pyramid_number, 0);
    wait_done(dnb, 100);
    repeat (5) tick();
    check("d_win_count", win_q.size() - wb, 4);
    if (win_q.size() > wb) begin
      check("d_first_lvl", win_q[wb].lvl, 0);
      check("d_first_cyc", win_q[wb].cyc - s, 5);
    end
    check("d_det_count", det_q.size() - db, 0);
    check("d_done_count", done_q.size() - dnb, 1);
    if (done_q.size() > dnb) check("d_done_cyc", done_q[dnb] - s, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vj_scan_ctrl.md
# vj_scan_ctrl

Window scheduler for the Viola-Jones face detector. Once an image is loaded it walks the image pyramid one level at a time. For each level it asks the pyramid/integral-image builder for that level, then issues every 24×24 window position to the VJ cascade pipeline at one window per cycle. It tags each window so the pipeline's pass/fail result can be matched back to its coordinates, emits the coordinates of windows that pass, and signals when the whole pyramid is finished. It sits between `detect_face`'s image-load logic, the pyramid builder and the `vjp` cascade.

## Interface
Parameters:
- `LEVELS`, default 10: number of pyramid levels, scanned from level 0 to `LEVELS-1`.
- `PIPE_LAT`, default 26: cycles from window issue to a valid `face_detected`.
- `DIM_W`, default 16: width of the level dimension and index buses.

Ports:
- `clock` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; image loaded (`laptop_img_rdy`).
- `busy` out 1: high from the cycle after an accepted `start` until `vj_pipeline_done`.
- `level_req` out 1: one-cycle pulse asking the builder to build level `pyramid_number`.
- `level_ready` in 1: the level's integral image is valid; `level_w` and `level_h` are sampled in this cycle.
- `level_w`, `level_h` in `DIM_W`: scaled width and height of the level.
- `win_valid` out 1: a window is issued this cycle.
- `row_index`, `col_index` out `DIM_W`: top-left corner of the issued window.
- `face_detected` in 1: cascade result for the window issued `PIPE_LAT` cycles earlier.
- `face_coords_ready` out 1: `face_coords` and `pyramid_number` hold a detection.
- `face_coords` out [1:0][31:0]: [0] is row, [1] is col, both zero-extended.
- `pyramid_number` out 4: level currently scanned, or the level of the reported detection.
- `vj_pipeline_done` out 1: one-cycle pulse when all levels are finished.

## Operation
States: IDLE → REQ → WAIT_LVL → SCAN → DRAIN → (REQ | DONE) → IDLE.

- **IDLE**
  - `start` moves to REQ and clears `pyramid_number` to 0.
- **REQ**
  - Pulses `level_req` for exactly one cycle, then goes to WAIT_LVL.
- **WAIT_LVL**
  - Waits for `level_ready` and latches `level_w`/`level_h`.
  - If `level_w < 24` or `level_h < 24`, no windows are issued and the level goes straight to DRAIN.
  - Otherwise goes to SCAN with row = col = 0.
- **SCAN**
  - Issues one window per cycle in row-major order: col runs 0..`level_w-24`, then row increments.
  - Total windows per level = (`level_h`-23)·(`level_w`-23).
  - After the window at (`level_h-24`, `level_w-24`) is issued, goes to DRAIN.
- **DRAIN**
  - Counts `PIPE_LAT+1` cycles so every result for the level is reported before the level buffer is reused.
  - Then: if `pyramid_number == LEVELS-1`, goes to DONE; otherwise increments `pyramid_number` and goes to REQ.
- **DONE**
  - Pulses `vj_pipeline_done` for one cycle, drops `busy`, returns to IDLE.

Tagging:
- Each issued window pushes {valid, row, col, level} into a `PIPE_LAT`-deep delay line.
- `face_detected` is honoured only when the delay-line output is valid; otherwise it is ignored.
- Index arithmetic is done at `DIM_W` width; the comparisons above never wrap.

## Timing
- Reset values: every output is 0 (`busy`, `level_req`, `win_valid`, `face_coords_ready`, `vj_pipeline_done`, indices, `face_coords`, `pyramid_number`).
  - The delay line is cleared, so no detection appears after reset.
- `start` accepted in cycle t:
  - `busy` and `level_req` are high in cycle t+1.
- `level_ready` in cycle t:
  - The first `win_valid` is in cycle t+1, and `win_valid` is high on consecutive cycles with no bubbles.
- Window issued in cycle t with `face_detected` high in t+`PIPE_LAT`:
  - `face_coords_ready` is high in t+`PIPE_LAT`+1 for one cycle, carrying the tagged coordinates and level.
  - Back-to-back detections give consecutive ready cycles.
- Edge conditions:
  - `start` while `busy` is ignored.
  - `level_ready` outside WAIT_LVL is ignored.
  - `reset` mid-scan aborts to IDLE on the next edge; no `vj_pipeline_done` is generated.

## Structure
- Package `vj_pkg` holds:
  - `WIN_SIZE = 24`.
  - `COORD_W = 32`.
  - The state enum typedef `vj_scan_state_t`.
  - The tag struct `vj_tag_t` {valid, row, col, level}.
- One sub-module, `vj_tag_pipe`: a parameterised, resettable delay line of `vj_tag_t`, `PIPE_LAT` deep.

## Test plan
Bench settings: `LEVELS=2`, `PIPE_LAT=4`, builder model asserts `level_ready` 3 cycles after `level_req`.

- **Single level, four windows**
  - Stimulus: level 0 is 25×25.
  - Expected: exactly 4 `win_valid` cycles at (0,0), (0,1), (1,0), (1,1), issued on consecutive cycles.
- **Detection report**
  - Stimulus: drive `face_detected` for window (1,0) only.
  - Expected: one `face_coords_ready` pulse with `face_coords`=(r1,c0) and `pyramid_number`=0, exactly 5 cycles after that window's issue.
- **Skipped level**
  - Stimulus: level 1 is 20×30.
  - Expected: zero windows for level 1; `vj_pipeline_done` 6 cycles after `level_ready`.
- **Spurious result**
  - Stimulus: `face_detected` held high during WAIT_LVL and REQ.
  - Expected: no `face_coords_ready`.
- **Reset mid-scan**
  - Stimulus: assert `reset` during SCAN of a 30×30 level.
  - Expected: all outputs 0 the next cycle, no detection or done afterwards, and a fresh `start` restarts at level 0.
- **Start while busy**
  - Stimulus: second `start` pulse during SCAN.
  - Expected: ignored; exactly one `vj_pipeline_done` pulse.
